// File: rtl/clock_reset_pkg.sv
// Shared defaults and types for the board clock-enable / reset generator.
package clock_reset_pkg;

  localparam int          CNT_W_DEFAULT = 32;
  localparam logic [31:0] DIV_DEFAULT   = 32'd25_000_000;
  localparam int          POR_DEFAULT   = 16;
  localparam int          SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_COUNT = 2'd1,
    CH_WRAP  = 2'd2
  } ch_phase_e;

  // Channel-select width; a single channel still needs a 1-bit port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, tick pulse, square wave and a
// shadow divisor that only takes effect on a period boundary.
module clk_div_chan
  import clock_reset_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic             sq
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  ch_phase_e        phase_s;

  // Classify the cycle: halted (no run, no enable, or divisor 0), counting, or terminal.
  always_comb begin
    if (!run || !en || (div_q == ZERO)) begin
      phase_s = CH_IDLE;
    end else if (cnt_q == (div_q - ONE)) begin
      phase_s = CH_WRAP;
    end else begin
      phase_s = CH_COUNT;
    end
  end

  // Next-state: a halted channel adopts a pending divisor at once, a running one only at wrap.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    tick_d    = 1'b0;
    sq_d      = sq_q;
    if (load) begin
      shadow_d  = load_val;
      pending_d = 1'b1;
    end else begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
    end
    case (phase_s)
      CH_IDLE: begin
        cnt_d = ZERO;
        if (pending_q) begin
          div_d     = shadow_q;
          pending_d = load;
        end else begin
          div_d = div_q;
        end
      end
      CH_WRAP: begin
        cnt_d  = ZERO;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
        if (load) begin
          div_d     = load_val;
          pending_d = 1'b0;
        end else if (pending_q) begin
          div_d     = shadow_q;
          pending_d = 1'b0;
        end else begin
          div_d = div_q;
        end
      end
      CH_COUNT: begin
        cnt_d = cnt_q + ONE;
      end
      default: begin
        cnt_d = ZERO;
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= ZERO;
      div_q     <= DIV_RST;
      shadow_q  <= DIV_RST;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/clock_reset_gen.sv
// Board-level reset stretcher and multi-channel clock-enable generator.
// Channels stay frozen until the stretched reset has been released.
module clock_reset_gen
  import clock_reset_pkg::*;
#(
  parameter int                      NUM_CH     = 4,
  parameter int                      CNT_W      = CNT_W_DEFAULT,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT   = {NUM_CH{CNT_W'(DIV_DEFAULT)}},
  parameter int                      POR_CYCLES = POR_DEFAULT
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic [NUM_CH-1:0]            en,
  input  logic                         div_load,
  input  logic [sel_width(NUM_CH)-1:0] div_sel,
  input  logic [CNT_W-1:0]             div_val,
  output logic [NUM_CH-1:0]            tick,
  output logic [NUM_CH-1:0]            sq,
  output logic                         rst_out,
  output logic                         rst_n_out,
  output logic                         por_done
);

  localparam int               POR_W    = $clog2(POR_CYCLES + 1);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [POR_W-1:0]       por_cnt_q, por_cnt_d;
  logic                   por_done_q, por_done_d;
  logic                   rst_out_q, rst_out_d;
  logic                   rst_n_out_q, rst_n_out_d;
  logic [NUM_CH-1:0]      load_s;

  // Release synchroniser and POR stretch counter; once done, reset stays released.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], 1'b1};
    por_done_d  = por_done_q;
    rst_out_d   = rst_out_q;
    rst_n_out_d = rst_n_out_q;
    if (sync_q[SYNC_STAGES-1] && !por_done_q) begin
      if (por_cnt_q == POR_LAST) begin
        por_cnt_d   = por_cnt_q;
        por_done_d  = 1'b1;
        rst_out_d   = 1'b0;
        rst_n_out_d = 1'b1;
      end else begin
        por_cnt_d = por_cnt_q + POR_W'(1);
      end
    end else begin
      por_cnt_d = por_cnt_q;
    end
  end

  // Reset-domain registers; clrn clears asynchronously, release is clocked.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q      <= {SYNC_STAGES{1'b0}};
      por_cnt_q   <= {POR_W{1'b0}};
      por_done_q  <= 1'b0;
      rst_out_q   <= 1'b1;
      rst_n_out_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      por_cnt_q   <= por_cnt_d;
      por_done_q  <= por_done_d;
      rst_out_q   <= rst_out_d;
      rst_n_out_q <= rst_n_out_d;
    end
  end

  // Load strobe decode; selects beyond the last channel match nothing.
  always_comb begin
    load_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (div_load && (int'(div_sel) == i)) begin
        load_s[i] = 1'b1;
      end else begin
        load_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_chan (
      .clk      (clk),
      .rst_n    (clrn),
      .run      (por_done_q),
      .en       (en[g]),
      .load     (load_s[g]),
      .load_val (div_val),
      .tick     (tick[g]),
      .sq       (sq[g])
    );
  end

  assign rst_out   = rst_out_q;
  assign rst_n_out = rst_n_out_q;
  assign por_done  = por_done_q;

endmodule

// File: tb/tb_clock_reset_gen.sv
// Scoreboard bench: stimulus queues hand-computed tick cycles, a monitor
// matches every observed tick (cycle and square-wave level) against them.
module tb_clock_reset_gen;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        clrn;
  logic [2:0]  en;
  logic        div_load;
  logic [1:0]  div_sel;
  logic [15:0] div_val;
  logic [2:0]  tick;
  logic [2:0]  sq;
  logic        rst_out;
  logic        rst_n_out;
  logic        por_done;

  typedef struct {
    int   ch;
    int   cyc;
    logic sq;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] sq_model = 3'b000;
  int         cyc      = 0;
  int         checks   = 0;
  int         errors   = 0;

  clock_reset_gen #(
    .NUM_CH     (NCH),
    .CNT_W      (16),
    .DIV_INIT   ({16'd5, 16'd10, 16'd4}),
    .POR_CYCLES (16)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .en        (en),
    .div_load  (div_load),
    .div_sel   (div_sel),
    .div_val   (div_val),
    .tick      (tick),
    .sq        (sq),
    .rst_out   (rst_out),
    .rst_n_out (rst_n_out),
    .por_done  (por_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every tick seen must be the oldest expected tick of its channel.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (tick[c] === 1'b1) begin
        int idx;
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (idx < 0 && exp_q[k].ch == c) idx = k;
        end
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL tick_unexpected ch%0d: got tick at cyc %0d, required none", c, cyc);
        end else begin
          if (exp_q[idx].cyc != cyc || exp_q[idx].sq !== sq[c]) begin
            errors++;
            $display("FAIL tick ch%0d: got cyc %0d sq %0b, required cyc %0d sq %0b",
                     c, cyc, sq[c], exp_q[idx].cyc, exp_q[idx].sq);
          end
          exp_q.delete(idx);
        end
      end
    end
  end

  task automatic push(input int ch, input int c);
    exp_t e;
    sq_model[ch] = ~sq_model[ch];
    e.ch  = ch;
    e.cyc = c;
    e.sq  = sq_model[ch];
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic do_load(input int s, input int v);
    div_load = 1'b1;
    div_sel  = s[1:0];
    div_val  = v[15:0];
    goto(cyc + 1);
    div_load = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; en = 3'b000; div_load = 1'b0; div_sel = 2'd0; div_val = 16'd0;

    // Power-on reset and stretch: release lands on the 18th edge after clrn rises.
    goto(5);
    chk("rst_tick", {29'd0, tick}, 32'd0);
    chk("rst_sq", {29'd0, sq}, 32'd0);
    chk("rst_out_init", {31'd0, rst_out}, 32'd1);
    chk("rst_n_out_init", {31'd0, rst_n_out}, 32'd0);
    chk("por_done_init", {31'd0, por_done}, 32'd0);
    clrn = 1'b1;
    en   = 3'b001;
    push(0, 27); push(0, 31); push(0, 35); push(0, 39); push(0, 43);
    push(0, 56); push(0, 60); push(0, 64);
    goto(22);
    chk("rst_out_edge17", {31'd0, rst_out}, 32'd1);
    chk("por_done_edge17", {31'd0, por_done}, 32'd0);
    goto(23);
    chk("rst_out_edge18", {31'd0, rst_out}, 32'd0);
    chk("rst_n_out_edge18", {31'd0, rst_n_out}, 32'd1);
    chk("por_done_edge18", {31'd0, por_done}, 32'd1);

    // Channel 0, D=4: 50% duty square wave.
    goto(29);
    chk("sq0_high_phase", {31'd0, sq[0]}, 32'd1);
    goto(33);
    chk("sq0_low_phase", {31'd0, sq[0]}, 32'd0);

    // Enable gap of 7 cycles on channel 0.
    goto(45); en = 3'b000;
    goto(52); en = 3'b001;
    goto(55);
    chk("sq0_held_gap", {31'd0, sq[0]}, 32'd1);
    goto(65); en = 3'b000;

    // Channel 1, D=10: reload mid-period (last write wins), then at terminal count.
    push(1, 80); push(1, 90); push(1, 93); push(1, 96); push(1, 99);
    push(1, 104); push(1, 109);
    goto(70); en = 3'b010;
    goto(82); do_load(1, 7);
    goto(84); do_load(1, 3);
    goto(98); do_load(1, 5);
    goto(110); en = 3'b000;

    // Channel 2, D=5 -> 0 (stall) -> 1 (every cycle).
    push(2, 120); push(2, 125); push(2, 130);
    for (int c = 144; c <= 150; c++) push(2, c);
    goto(115); en = 3'b100;
    goto(126); do_load(2, 0);
    goto(140);
    chk("sq2_frozen_stall", {31'd0, sq[2]}, 32'd1);
    goto(141); do_load(2, 1);
    goto(150); en = 3'b000;
    goto(152);
    chk("sq_after_tests", {29'd0, sq}, 32'h2);

    // Asynchronous clear mid-operation with loaded divisors.
    push(0, 159); push(1, 160);
    for (int c = 156; c <= 160; c++) push(2, c);
    goto(155); en = 3'b111;
    goto(161);
    clrn = 1'b0;
    #1;
    chk("async_tick", {29'd0, tick}, 32'd0);
    chk("async_sq", {29'd0, sq}, 32'd0);
    chk("async_rst_out", {31'd0, rst_out}, 32'd1);
    chk("async_rst_n_out", {31'd0, rst_n_out}, 32'd0);
    chk("async_por_done", {31'd0, por_done}, 32'd0);
    sq_model = 3'b000;

    // After release, divisors are back to DIV_INIT; out-of-range selects ignored.
    push(0, 186); push(0, 190); push(0, 194);
    push(1, 192);
    push(2, 187); push(2, 192); push(2, 197);
    goto(164);
    clrn = 1'b1;
    do_load(3, 2);
    goto(181);
    chk("por_done_re_edge17", {31'd0, por_done}, 32'd0);
    goto(182);
    chk("por_done_re_edge18", {31'd0, por_done}, 32'd1);
    goto(185); do_load(3, 2);
    goto(197); en = 3'b000;
    goto(202);
    chk("sq_final", {29'd0, sq}, 32'h7);
    chk("exp_queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
